dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 82 ++++++++
 tb/tb_dmem_port_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-port dmem arbiter between the load unit and the store-buffer retire head.
// Define DMEM_ARB_STARVE_EN to compile in the store aging counter.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned LD_LAT     = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prmiss,
  input  logic                ld_req,
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                ld_ack,
  output logic                ld_valid,
  output logic [DATA_LEN-1:0] ld_data,
  input  logic                st_pend,
  input  logic                sb_full,
  output logic                memoccupy_ld,
  input  logic                stretire,
  input  logic [ADDR_LEN-1:0] retaddr,
  input  logic [DATA_LEN-1:0] retdata,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_LEN-1:0] dmem_rdata
);

  logic              st_prio;
  logic [LD_LAT-1:0] ifl;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] starve_cnt;

  assign st_prio = st_pend & (sb_full | (starve_cnt == LIM));

  // Counts cycles a ready store loses the port to a load; a retire resets it.
  always_ff @(posedge clk) begin
    if (!reset || stretire) begin
      starve_cnt <= '0;
    end else if (st_pend && ld_ack && (starve_cnt != LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign st_prio = st_pend & sb_full;
`endif

  assign ld_ack       = reset & ld_req & ~prmiss & ~st_prio;
  assign memoccupy_ld = ld_ack;

  assign dmem_addr  = ld_ack ? ld_addr : retaddr;
  assign dmem_we    = stretire & ~ld_ack & reset;
  assign dmem_wdata = retdata;

  // A mispredict squashes everything in flight; the return in that cycle still shows.
  generate
    if (LD_LAT == 1) begin : g_ifl_one
      always_ff @(posedge clk) begin
        if (!reset || prmiss) begin
          ifl <= '0;
        end else begin
          ifl <= ld_ack;
        end
      end
    end else begin : g_ifl_many
      always_ff @(posedge clk) begin
        if (!reset || prmiss) begin
          ifl <= '0;
        end else begin
          ifl <= {ifl[LD_LAT-2:0], ld_ack};
        end
      end
    end
  endgenerate

  assign ld_valid = ifl[LD_LAT-1] & reset;
  assign ld_data  = dmem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized bench for dmem_port_arbiter against a queue-based model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned LIM = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, prmiss, ld_req, st_pend, sb_full, stretire;
  logic [AW-1:0] ld_addr, retaddr, dmem_addr;
  logic [DW-1:0] retdata, dmem_rdata, ld_data, dmem_wdata;
  logic          ld_ack, ld_valid, memoccupy_ld, dmem_we;

  dmem_port_arbiter #(
    .ADDR_LEN(AW), .DATA_LEN(DW), .LD_LAT(LAT), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .reset(reset), .prmiss(prmiss), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_ack(ld_ack), .ld_valid(ld_valid), .ld_data(ld_data), .st_pend(st_pend),
    .sb_full(sb_full), .memoccupy_ld(memoccupy_ld), .stretire(stretire),
    .retaddr(retaddr), .retdata(retdata), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: store age in cycles blocked, and the cycle numbers at which loads return.
  int age = 0;
  int due_q[$];
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs mid-cycle, advance the model.
  task automatic step(input logic rst_v, input logic prm, input logic lr, input logic sp,
                      input logic sf, input logic want_ret, input logic [AW-1:0] la);
    bit e_prio, e_ack, e_ret, e_valid;
    int q2[$];
    e_prio = sp && (sf || (STARVE && age == int'(LIM)));
    e_ack  = rst_v && lr && !prm && !e_prio;
    e_ret  = want_ret && sp && !e_ack && !prm;
    e_valid = 1'b0;
    foreach (due_q[i]) if (due_q[i] == cyc) e_valid = 1'b1;
    e_valid = e_valid && rst_v;

    reset = rst_v; prmiss = prm; ld_req = lr; st_pend = sp; sb_full = sf;
    stretire = e_ret; ld_addr = la;
    retaddr = $urandom; retdata = $urandom; dmem_rdata = $urandom;
    #1;
    chk("ld_ack", 32'(ld_ack), 32'(e_ack));
    chk("memoccupy_ld", 32'(memoccupy_ld), 32'(e_ack));
    chk("dmem_we", 32'(dmem_we), 32'(e_ret && rst_v));
    chk("ld_valid", 32'(ld_valid), 32'(e_valid));
    chk("dmem_wdata", dmem_wdata, retdata);
    if (e_ack) chk("dmem_addr_ld", dmem_addr, la);
    if (e_ret) chk("dmem_addr_st", dmem_addr, retaddr);
    if (e_valid) chk("ld_data", ld_data, dmem_rdata);

    if (!rst_v) begin
      age = 0;
      due_q.delete();
    end else begin
      if (e_ret) age = 0;
      else if (sp && e_ack && age < int'(LIM)) age++;
      foreach (due_q[i]) if (due_q[i] > cyc && !prm) q2.push_back(due_q[i]);
      due_q = q2;
      if (e_ack) due_q.push_back(cyc + int'(LAT));
    end
    @(negedge clk);
    cyc++;
  endtask

  int acks;

  initial begin
    reset = 1'b0; prmiss = 1'b0; ld_req = 1'b0; st_pend = 1'b0; sb_full = 1'b0;
    stretire = 1'b0; ld_addr = '0; retaddr = '0; retdata = '0; dmem_rdata = '0;
    @(negedge clk);

    // Reset held with both requesters active.
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single load with return LAT cycles later.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Starvation: load and store both held; count the load grants in 12 cycles.
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200 + 32'(i * 4));
      acks += int'(ld_ack);
    end
    chk("starve_acks", 32'(acks), STARVE ? 32'd10 : 32'd12);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Full-buffer override, then sb_full alone not blocking loads.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Mispredict: two back-to-back loads, prmiss two cycles after the first.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h404);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h408);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a load drops its return.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Idle.
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           32'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
